// File: rtl/pool_sequencer.sv
// 2x2 stride-2 signed max-pool with ReLU over the per-channel result banks.
// One read per window pixel, all lanes reduced in parallel, one compact write per window.
module pool_sequencer #(
    parameter int IMG_W    = 28,
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 8,
    parameter int ADDR_W   = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         rd_en,
    output logic [ADDR_W-1:0]            rd_addr,
    input  logic [CHANNELS*DATA_W-1:0]   rd_data,
    output logic                         wr_en,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic [CHANNELS*DATA_W-1:0]   wr_data
);

    localparam int HALF = IMG_W / 2;

    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO      = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] ROW_A    = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W + 2);
    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(HALF - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(HALF * HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_RD2,
        S_RD3,
        S_LAST,
        S_WR,
        S_DONE
    } state_e;

    typedef logic [CHANNELS-1:0][DATA_W-1:0] lanes_t;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    lanes_t            max_q, max_d;

    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]          rd_addr_q, rd_addr_d;
    logic                       wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]          wr_addr_q, wr_addr_d;
    logic [CHANNELS*DATA_W-1:0] wr_data_q, wr_data_d;

    function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? '0 : v;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_RD0;
            S_RD0:   state_d = S_RD1;
            S_RD1:   state_d = S_RD2;
            S_RD2:   state_d = S_RD3;
            S_RD3:   state_d = S_LAST;
            S_LAST:  state_d = S_WR;
            S_WR:    state_d = (idx_q == IDX_LAST) ? S_DONE : S_RD0;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Window walk: base steps by 2 along a row, jumps a full row at the row end
    always_comb begin
        base_d = base_q;
        col_d  = col_q;
        idx_d  = idx_q;
        if (state_q == S_IDLE && start) begin
            base_d = '0;
            col_d  = '0;
            idx_d  = '0;
        end else if (state_q == S_WR) begin
            idx_d = idx_q + ONE;
            if (col_q == COL_LAST) begin
                base_d = base_q + ROW_STEP;
                col_d  = '0;
            end else begin
                base_d = base_q + TWO;
                col_d  = col_q + ONE;
            end
        end
    end

    // Read data lags rd_en by one cycle, so capture runs RD1..LAST
    always_comb begin
        max_d = max_q;
        for (int c = 0; c < CHANNELS; c++) begin
            if (state_q == S_RD1) begin
                max_d[c] = rd_data[c*DATA_W +: DATA_W];
            end else if (state_q == S_RD2 || state_q == S_RD3 ||
                         state_q == S_LAST) begin
                if ($signed(rd_data[c*DATA_W +: DATA_W]) >
                    $signed(max_q[c])) begin
                    max_d[c] = rd_data[c*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q <= '0;
            col_q  <= '0;
            idx_q  <= '0;
            max_q  <= '0;
        end else begin
            base_q <= base_d;
            col_q  <= base_q == base_d ? col_q : col_d;
            idx_q  <= idx_d;
            max_q  <= max_d;
        end
    end

    // Output logic, decoded from the next state so every port is a flop
    always_comb begin
        busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d    = (state_d == S_DONE);
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        unique case (state_d)
            S_RD0: begin
                rd_en_d   = 1'b1;
                rd_addr_d = base_d;
            end
            S_RD1: begin
                rd_en_d   = 1'b1;
                rd_addr_d = base_d + ONE;
            end
            S_RD2: begin
                rd_en_d   = 1'b1;
                rd_addr_d = base_d + ROW_A;
            end
            S_RD3: begin
                rd_en_d   = 1'b1;
                rd_addr_d = base_d + ROW_A + ONE;
            end
            S_WR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = idx_d;
                for (int c = 0; c < CHANNELS; c++) begin
                    wr_data_d[c*DATA_W +: DATA_W] = relu(max_d[c]);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule
